// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the FIFO read-side arbiter: FSM encoding and
// helpers that size the burst counter and round-robin pointer.
package fifo_rd_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  // Counter must reach burst_max itself, hence the extra bit.
  function automatic int cnt_width(input int max_pops);
    return $clog2(max_pops) + 1;
  endfunction

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after
// ptr, wrapping modulo n_req.
module rr_pick #(
  parameter int n_req = 4,
  parameter int ptr_w = 2
) (
  input  logic [n_req-1:0] req,
  input  logic [ptr_w-1:0] ptr,
  output logic [n_req-1:0] winner,
  output logic             any
);

  logic [ptr_w-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int i = 0; i < n_req; i++) begin
      idx = ptr_w'((int'(ptr) + i) % n_req);
      if (!any && req[idx]) begin
        winner[idx] = 1'b1;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter: grants one requester a burst of up to burst_max pops
// from a shared FIFO, round-robin between bursts.
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int n_req     = 4,
  parameter int data_size = 8,
  parameter int burst_max = 4
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [n_req-1:0]     req,
  input  logic                 rempty,
  input  logic [data_size-1:0] rdata,
  output logic                 rinc,
  output logic [n_req-1:0]     gnt,
  output logic [n_req-1:0]     dvalid,
  output logic [data_size-1:0] dout
);

  localparam int CNT_W = cnt_width(burst_max);
  localparam int PTR_W = ptr_width(n_req);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(burst_max - 1);
  localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(n_req - 1);

  arb_state_e state_q, state_d;

  logic [n_req-1:0]     gnt_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [n_req-1:0]     vld_p1;
  logic [data_size-1:0] dout_p1;

  logic [n_req-1:0] pick_winner;
  logic             pick_any;
  logic [PTR_W-1:0] owner_idx;
  logic [PTR_W-1:0] ptr_next;
  logic             owner_req;
  logic             grant_go;
  logic             release_burst;
  logic             last_pop;

  rr_pick #(
    .n_req (n_req),
    .ptr_w (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < n_req; i++) begin
      if (gnt_q[i]) owner_idx = PTR_W'(i);
    end
  end

  assign owner_req = |(req & gnt_q);
  assign ptr_next  = (owner_idx == PTR_TOP) ? '0 : owner_idx + 1'b1;

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_go)      state_d = ST_BURST;
      ST_BURST: if (release_burst) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // A pop that hits the burst limit still completes in its release cycle.
  always_comb begin
    grant_go      = 1'b0;
    rinc          = 1'b0;
    last_pop      = 1'b0;
    release_burst = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_go = pick_any && !rempty;
      end
      ST_BURST: begin
        rinc          = owner_req && !rempty;
        last_pop      = rinc && (cnt_q == CNT_LAST);
        release_burst = !owner_req || rempty || last_pop;
      end
      default: begin
        grant_go = 1'b0;
      end
    endcase
  end

  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      gnt_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (grant_go) begin
        gnt_q <= pick_winner;
      end else if (release_burst) begin
        gnt_q <= '0;
        ptr_q <= ptr_next;
      end
      if (grant_go)  cnt_q <= '0;
      else if (rinc) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Stage p1: popped word and its owner, one cycle after the pop strobe.
  always_ff @(posedge rclk or negedge rrst) begin
    if (!rrst) begin
      vld_p1  <= '0;
      dout_p1 <= '0;
    end else begin
      vld_p1 <= rinc ? gnt_q : '0;
      if (rinc) dout_p1 <= rdata;
    end
  end

  assign gnt    = gnt_q;
  assign dvalid = vld_p1;
  assign dout   = dout_p1;

  a_gnt_onehot: assert property (@(posedge rclk) disable iff (!rrst)
    $onehot0(gnt_q));
  a_gnt_idle: assert property (@(posedge rclk) disable iff (!rrst)
    (state_q == ST_IDLE) |-> (gnt_q == '0));
  a_no_pop_empty: assert property (@(posedge rclk) disable iff (!rrst)
    rempty |-> !rinc);
  a_burst_owned: assert property (@(posedge rclk) disable iff (!rrst)
    (state_q == ST_BURST) |-> (gnt_q != '0));

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter n_req, default 4: number of read requesters (2..8).
REQ-002 Parameter data_size, default 8: FIFO word width.
REQ-003 Parameter burst_max, default 4: max pops per grant (1..16).
REQ-004 rclk  input  1  read-domain clock; all state updates on posedge rclk.
REQ-005 rrst  input  1  reset; asynchronous, active-low.
REQ-006 req  input  n_req  per-requester read request, level.
REQ-007 rempty  input  1  FIFO read-side empty flag, registered in rclk domain.
REQ-008 rdata  input  data_size  FIFO memory word at current raddr, combinational.
REQ-009 rinc  output  1  pop strobe to FIFO read pointer logic.
REQ-010 gnt  output  n_req  one-hot registered grant; all-zero when idle.
REQ-011 dvalid  output  n_req  one-hot; dout belongs to the flagged requester this cycle.
REQ-012 dout  output  data_size  registered popped word.

Function
REQ-013 FSM states: IDLE, BURST; gnt nonzero only in BURST.
REQ-014 IDLE: if (req != 0) and !rempty, select winner by round-robin starting at index ptr, wrapping modulo n_req; next cycle state=BURST, gnt=onehot(winner), cnt=0.
REQ-015 IDLE with rempty=1 or req=0: stay IDLE, gnt=0, no pop.
REQ-016 BURST: rinc = req[owner] & !rempty, combinational from registered gnt.
REQ-017 Each cycle rinc=1: dout<=rdata, dvalid<=gnt (1-cycle latency); otherwise dvalid<=0, dout holds.
REQ-018 Each pop increments cnt (width clog2(burst_max)+1, no wrap).
REQ-019 Release to IDLE, gnt<=0, ptr<=(owner+1) mod n_req when: req[owner]=0, or rempty=1, or a pop occurs with cnt=burst_max-1.
REQ-020 On release caused by a pop, that pop completes (rinc=1 in the release cycle).
REQ-021 rempty rising mid-burst: no pop that cycle; release same edge.
REQ-022 Requests from other indices never preempt an active burst.
REQ-023 Never more than one pop per cycle; rinc never asserted while rempty=1.
REQ-024 Minimum gap between bursts: one IDLE cycle (arbitration cycle).

Reset
REQ-025 rrst=0 asynchronously forces: state=IDLE, gnt=0, rinc=0, dvalid=0, dout=0, ptr=0, cnt=0.
REQ-026 Reset mid-burst aborts the burst; no pop and no dvalid until one full IDLE arbitration after rrst deasserts.

Structure
REQ-027 Shared package holds FSM state encoding and the clog2-derived cnt width.
REQ-028 One sub-module, rr_pick: combinational round-robin selector (req, ptr -> one-hot winner, any).
REQ-029 rinc is the only combinational output; gnt, dvalid, dout are registered.

Verification
REQ-030 Reset: rrst=0 for 3 cycles with req=4'b1111, rempty=0 -> gnt=0, rinc=0, dvalid=0, dout=0 throughout.
REQ-031 Single requester: req=4'b0010, FIFO holds 0x11,0x22,0x33 -> gnt=4'b0010 after 1 cycle; dvalid=4'b0010 three consecutive cycles with dout 0x11,0x22,0x33; release on rempty; ptr=2.
REQ-032 Burst limit: req=4'b0001 held, 10 words, burst_max=4 -> exactly 4 pops, release, 1 IDLE cycle, re-grant to req0 (only requester), next 4 pops.
REQ-033 Round-robin fairness: req=4'b1111 held, FIFO never empty -> grant order 0,1,2,3,0; each burst 4 pops.
REQ-034 Requester drop: req0 granted, req[0] deasserted after 2 pops -> rinc=0 that cycle, release, ptr=1; req[1] waiting is granted next IDLE arbitration.
REQ-035 Reset mid-burst: rrst pulsed low after 2 pops of 4 -> outputs clear immediately; after release, ptr=0 arbitration restarts with req0.
